sub_serial_16_bit: RTL and testbench
====================================

Name: sub_serial_16_bit

Overview:
Multi-cycle, digit-serial 16-bit subtractor computing d = a - b - b_in. It processes one DIGIT-bit slice per clock, least-significant slice first, and propagates the borrow through a register between slices.
It is the subtract counterpart of the team's 16-bit ripple adder and trades latency for a single narrow slice datapath.
A start/busy/done handshake lets it sit beside the adder in the ALU datapath. It also produces unsigned-borrow and signed status flags.

Parameters:
WIDTH, 16, operand/result width in bits
DIGIT, 4, bits processed per RUN cycle; must divide WIDTH (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
b_in  input  1  borrow-in, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse: result valid
d  output  WIDTH  difference
b_out  output  1  borrow out of MSB; 1 iff unsigned a < b + b_in
zero  output  1  d == 0
neg  output  1  d[WIDTH-1]
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) and (d[MSB] != a[MSB])

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - busy, done, d, b_out, zero, neg and ovf = 0.
  - Internal operand, borrow and slice-index registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: capture a, b and b_in into operand registers; clear the slice index; go to RUN.
- RUN (NSLICE = WIDTH/DIGIT cycles):
  - Each cycle, subtract slice k: a_k + ~b_k + ~borrow. Use the slice's carry-out inverted as the next borrow.
  - Write the slice result into the partial-result register; increment k.
  - On the last slice (k = NSLICE-1), load d, b_out, zero, neg and ovf from the completed result; go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Without start: return to IDLE.
  - With start=1: accept the new operands exactly as IDLE does and go to RUN. Back-to-back operations therefore run with no bubble beyond the DONE cycle.
- busy:
  - 1 in RUN only, and registered.
  - Goes high the cycle after start is accepted and drops in the same cycle done rises.
- Latency:
  - Start sampled at edge E; done is high in the cycle following edge E+NSLICE (4 cycles for the defaults).
  - Throughput: one result per NSLICE+1 cycles.
- start while busy=1: ignored. Captured operands are unaffected.
- Output stability:
  - d and all flags hold the previous result throughout RUN.
  - They change only on the final-slice edge and then hold until the next completion or reset.
- Input stability: a, b and b_in are don't-care after the capture edge.
- Reset mid-RUN: the operation is abandoned; no done pulse; all outputs go to 0.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Borrow chain identical to a ripple subtractor, so b_out equals the inverted final carry of a + ~b + ~b_in.

Decomposition:
- Shared package sub_serial_pkg containing:
  - the state enum typedef (IDLE/RUN/DONE);
  - the default WIDTH and DIGIT constants;
  - the derived NSLICE constant and the slice-index width.
- One sub-module, digit_sub_slice: combinational DIGIT-bit subtract slice with inputs x, y and borrow_in, and outputs diff and borrow_out.
  - It is instantiated once and time-multiplexed by the FSM.

Test Plan:
1. a=0x1234, b=0x0034, b_in=0, start for 1 cycle -> done exactly 4 cycles after the start edge; d=0x1200, b_out=0, zero=0, neg=0, ovf=0; busy high for 4 cycles.
2. a=0x0000, b=0x0001, b_in=0 -> d=0xFFFF, b_out=1, neg=1, ovf=0, zero=0.
3. a=0x8000, b=0x0001, b_in=0 -> d=0x7FFF, ovf=1, b_out=0, neg=0.
4. a=0x5555, b=0x5554, b_in=1 -> d=0x0000, zero=1, b_out=0. Then, in the done cycle, start with a=0x0010, b=0x0020 -> next done 5 cycles later with d=0xFFF0, b_out=1, neg=1.
5. Pulse start again during RUN with different operands -> ignored; the result matches the first operands only. During RUN, d still shows the prior result.
6. Assert rst_n=0 in the 2nd RUN cycle -> all outputs 0 immediately and no done pulse. After release, a fresh start with a=0xFFFF, b=0xFFFF -> d=0, zero=1.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGIT  = 4;
    localparam int DEF_NSLICE = DEF_WIDTH / DEF_DIGIT;

    // A lone slice still needs a 1-bit index register.
    function automatic int slice_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int DEF_KW = slice_idx_w(DEF_NSLICE);

endpackage

// File: rtl/digit_sub_slice.sv
// One DIGIT-bit subtract slice: x - y - borrow_in as x + ~y + ~borrow_in.
module digit_sub_slice #(
    parameter int DIGIT = sub_serial_pkg::DEF_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             borrow_in,
    output logic [DIGIT-1:0] diff,
    output logic             borrow_out
);

    logic [DIGIT:0] sum;

    assign sum        = {1'b0, x} + {1'b0, ~y} + {{DIGIT{1'b0}}, ~borrow_in};
    assign diff       = sum[DIGIT-1:0];
    assign borrow_out = ~sum[DIGIT];

endmodule

// File: rtl/sub_serial_16_bit.sv
// Digit-serial subtractor: one slice per RUN cycle, LSB slice first, borrow
// carried in a register; start/busy/done handshake plus borrow and sign flags.
module sub_serial_16_bit
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int KW     = slice_idx_w(NSLICE);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("sub_serial_16_bit: DIGIT must divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d;
    logic             borrow_q, borrow_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [DIGIT-1:0] slice_diff;
    logic             slice_bo;

    // Operands shift right each cycle so the slice always reads the low digit;
    // the result shifts in from the top and is aligned after NSLICE steps.
    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x          (a_q[DIGIT-1:0]),
        .y          (b_q[DIGIT-1:0]),
        .borrow_in  (borrow_q),
        .diff       (slice_diff),
        .borrow_out (slice_bo)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        borrow_d = borrow_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        d_d      = d_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                part_d   = part_q >> DIGIT;
                part_d[WIDTH-1 -: DIGIT] = slice_diff;
                borrow_d = slice_bo;
                k_d      = k_q + KW'(1);
                if (k_q == KW'(NSLICE - 1)) begin
                    state_d = DONE;
                    d_d     = part_d;
                    bout_d  = slice_bo;
                    zero_d  = (part_d == '0);
                    neg_d   = part_d[WIDTH-1];
                    ovf_d   = (amsb_q != bmsb_q) && (part_d[WIDTH-1] != amsb_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // IDLE and DONE accept a new operation identically.
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d  = RUN;
            a_d      = a;
            b_d      = b;
            borrow_d = b_in;
            amsb_d   = a[WIDTH-1];
            bmsb_d   = b[WIDTH-1];
            k_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            borrow_q <= borrow_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign d     = d_q;
    assign b_out = bout_q;
    assign zero  = zero_q;
    assign neg   = neg_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_serial_16_bit.sv
// Directed bench for sub_serial_16_bit: latency, flags, back-to-back, ignored
// start while busy, and reset mid-operation.
module tb_sub_serial_16_bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        b_in;
    logic        busy, done, b_out, zero, neg, ovf;
    logic [15:0] d;

    int tests = 0;
    int fails = 0;
    int lat, bcnt, pulses;

    sub_serial_16_bit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
        .busy(busy), .done(done), .d(d), .b_out(b_out), .zero(zero),
        .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch from the current cycle, then wait (bounded) for done.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          output int latency, output int busy_cycles);
        a = av; b = bv; b_in = bi; start = 1'b1;
        tick;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; b_in = 1'b1;
        busy_cycles = busy ? 1 : 0;
        latency = 0;
        while (!done && latency < 20) begin
            tick;
            latency++;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] ed, input logic eb,
                           input logic ez, input logic en, input logic eo);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".d"},    d,    ed);
        chk({tag, ".bout"}, b_out, eb);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".neg"},  neg,  en);
        chk({tag, ".ovf"},  ovf,  eo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.d", d, 16'h0000);
        chk("rst.flags", {b_out, zero, neg, ovf}, 4'b0000);
        rst_n = 1'b1;
        tick;

        // 1: basic, latency and busy width
        run_op(16'h1234, 16'h0034, 1'b0, lat, bcnt);
        chk("t1.lat", lat, 4);
        chk("t1.busycnt", bcnt, 4);
        chk_res("t1", 16'h1200, 0, 0, 0, 0);
        tick;
        chk("t1.done_pulse", done, 1'b0);

        // 2: underflow
        run_op(16'h0000, 16'h0001, 1'b0, lat, bcnt);
        chk("t2.lat", lat, 4);
        chk_res("t2", 16'hFFFF, 1, 0, 1, 0);
        tick;

        // 3: signed overflow
        run_op(16'h8000, 16'h0001, 1'b0, lat, bcnt);
        chk_res("t3", 16'h7FFF, 0, 0, 0, 1);
        tick;

        // borrow-in propagating through every slice
        run_op(16'h0000, 16'hFFFF, 1'b1, lat, bcnt);
        chk_res("tbin", 16'h0000, 1, 1, 0, 0);
        tick;

        // 4: zero result, then back-to-back start in the done cycle
        run_op(16'h5555, 16'h5554, 1'b1, lat, bcnt);
        chk_res("t4a", 16'h0000, 0, 1, 0, 0);
        run_op(16'h0010, 16'h0020, 1'b0, lat, bcnt);
        chk("t4b.lat", lat, 4);
        chk_res("t4b", 16'hFFF0, 1, 0, 1, 0);
        tick;
        chk("t4b.idle", {busy, done}, 2'b00);

        // 5: start pulsed during RUN is ignored; d holds prior result
        a = 16'h0100; b = 16'h0001; b_in = 1'b0; start = 1'b1;
        tick;
        a = 16'hFFFF; b = 16'h0000; b_in = 1'b1;
        tick;
        chk("t5.busy", busy, 1'b1);
        chk("t5.hold", d, 16'hFFF0);
        tick;
        start = 1'b0;
        chk("t5.hold2", d, 16'hFFF0);
        tick;
        tick;
        chk_res("t5", 16'h00FF, 0, 0, 0, 0);
        tick;
        chk("t5.noretrig", {busy, done}, 2'b00);

        // 6: reset in the 2nd RUN cycle
        a = 16'h1111; b = 16'h2222; b_in = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("t6.d", d, 16'h0000);
        chk("t6.bd", {busy, done}, 2'b00);
        pulses = 0;
        repeat (2) begin tick; if (done) pulses++; end
        rst_n = 1'b1;
        repeat (6) begin tick; if (done || busy) pulses++; end
        chk("t6.nodone", pulses, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bcnt);
        chk("t6.lat", lat, 4);
        chk_res("t6", 16'h0000, 0, 1, 0, 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
